// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared types and sizing helpers for the decoder scan sequencer.
package decoder_scan_pkg;

  localparam int STATE_W = 2;
  localparam int IDX_W   = 3;
  localparam int NUM_OUT = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  // Width of the blank down-counter; it is loaded with BLANK_CYCLES-1.
  function automatic int blank_cnt_w(input int blank_cycles);
    return (blank_cycles <= 2) ? 1 : $clog2(blank_cycles);
  endfunction

endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// Control/status bundle between the sweep controller (master) and the sequencer (slave).
interface decoder_scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               continuous;
  logic [DWELL_W-1:0] dwell;
  logic [7:0]         skip_mask;
  logic               en;
  logic               A;
  logic               B;
  logic               C;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, continuous, dwell, skip_mask,
    input  en, A, B, C, busy, done
  );

  modport slave (
    input  start, stop, continuous, dwell, skip_mask,
    output en, A, B, C, busy, done
  );
endinterface

// File: rtl/decoder_scan_sequencer_scan_next_idx.sv
// Priority search for the lowest unmasked decoder index above idx_i (or from 0 in first mode).
module scan_next_idx
  import decoder_scan_pkg::*;
(
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [NUM_OUT-1:0] mask_i,
  input  logic               first_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    // Descending scan so the last hit, i.e. the lowest candidate, wins.
    for (int i = NUM_OUT - 1; i >= 0; i--) begin
      if (!mask_i[i] && (first_i || (i > int'(idx_i)))) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Drives en/A/B/C of a 3-to-8 decoder so unmasked outputs fire one at a time, with blanking gaps.
module decoder_scan_sequencer
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  decoder_scan_sequencer_if.slave   bus
);

  localparam int BW = blank_cnt_w(BLANK_CYCLES);
  localparam logic [BW-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? BW'(BLANK_CYCLES - 1) : '0;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_OUT-1:0] mask_q;
  logic [BW-1:0]      blank_cnt_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic               en_q, busy_q, done_q;

  logic [NUM_OUT-1:0] first_mask;
  logic               first_found, next_found;
  logic [IDX_W-1:0]   first_idx, next_idx;
  logic               launch;
  logic [IDX_W-1:0]   launch_idx;

  // In IDLE the first index comes from the live mask, since it is latched on that same edge.
  assign first_mask = (state_q == ST_IDLE) ? bus.skip_mask : mask_q;

  scan_next_idx u_first (
    .idx_i   (idx_q),
    .mask_i  (first_mask),
    .first_i (1'b1),
    .found_o (first_found),
    .idx_o   (first_idx)
  );

  scan_next_idx u_next (
    .idx_i   (idx_q),
    .mask_i  (mask_q),
    .first_i (1'b0),
    .found_o (next_found),
    .idx_o   (next_idx)
  );

  always_comb begin
    launch     = 1'b0;
    launch_idx = first_idx;
    if (state_q == ST_IDLE) begin
      launch = bus.start && !bus.stop && first_found;
    end else if (state_q == ST_DRIVE && !bus.stop && dwell_cnt_q == '0) begin
      launch     = next_found || (bus.continuous && first_found);
      launch_idx = next_found ? next_idx : first_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      mask_q      <= '0;
      blank_cnt_q <= '0;
      dwell_cnt_q <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != ST_IDLE && bus.stop) begin
        state_q <= ST_IDLE;
        en_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else if (launch) begin
        if (state_q == ST_IDLE) mask_q <= bus.skip_mask;
        idx_q  <= launch_idx;
        busy_q <= 1'b1;
        if (BLANK_CYCLES > 0) begin
          state_q     <= ST_BLANK;
          blank_cnt_q <= BLANK_LOAD;
          en_q        <= 1'b0;
        end else begin
          state_q     <= ST_DRIVE;
          dwell_cnt_q <= bus.dwell;
          en_q        <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            // Start with every output masked: report completion without sweeping.
            if (bus.start && !bus.stop) begin
              mask_q <= bus.skip_mask;
              done_q <= 1'b1;
            end
          end
          ST_BLANK: begin
            if (blank_cnt_q == '0) begin
              state_q     <= ST_DRIVE;
              dwell_cnt_q <= bus.dwell;
              en_q        <= 1'b1;
            end else begin
              blank_cnt_q <= blank_cnt_q - BW'(1);
            end
          end
          ST_DRIVE: begin
            if (dwell_cnt_q == '0) begin
              state_q <= ST_IDLE;
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.en   = en_q;
  assign bus.A    = idx_q[2];
  assign bus.B    = idx_q[1];
  assign bus.C    = idx_q[0];
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
